// File: rtl/dram_arbiter.sv
// Single-port data RAM sequencer: arbitrates ext (absolute priority) and two
// cores (round-robin) onto one RAM, with a req/gnt/rvalid handshake per requester.
module dram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ext_req,
  input  logic              c0_req,
  input  logic              c1_req,
  input  logic              ext_we,
  input  logic              c0_we,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              ext_gnt,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              ext_rvalid,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [DATA_W-1:0] c0_rdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  typedef enum logic [1:0] {OWN_EXT, OWN_C0, OWN_C1} owner_t;

  state_t             state;
  owner_t             owner;
  logic               lat_we;
  logic               rr_last;
  logic [CNT_W-1:0]   cnt;

  logic               pick_valid;
  owner_t             pick;
  logic               pick_we;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_wdata;

  // rr_last names the core granted most recently; on a tie the other core wins.
  always_comb begin
    pick_valid = ext_req | c0_req | c1_req;
    pick       = OWN_C1;
    if (ext_req)
      pick = OWN_EXT;
    else if (c0_req && c1_req)
      pick = rr_last ? OWN_C0 : OWN_C1;
    else if (c0_req)
      pick = OWN_C0;

    pick_we    = c1_we;
    pick_addr  = c1_addr;
    pick_wdata = c1_wdata;
    case (pick)
      OWN_EXT: begin
        pick_we    = ext_we;
        pick_addr  = ext_addr;
        pick_wdata = ext_wdata;
      end
      OWN_C0: begin
        pick_we    = c0_we;
        pick_addr  = c0_addr;
        pick_wdata = c0_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= OWN_EXT;
      lat_we       <= 1'b0;
      rr_last      <= 1'b1;
      cnt          <= '0;
      ext_gnt      <= 1'b0;
      c0_gnt       <= 1'b0;
      c1_gnt       <= 1'b0;
      ext_rvalid   <= 1'b0;
      c0_rvalid    <= 1'b0;
      c1_rvalid    <= 1'b0;
      ext_rdata    <= '0;
      c0_rdata     <= '0;
      c1_rdata     <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      busy         <= 1'b0;
    end else begin
      ext_gnt      <= 1'b0;
      c0_gnt       <= 1'b0;
      c1_gnt       <= 1'b0;
      ext_rvalid   <= 1'b0;
      c0_rvalid    <= 1'b0;
      c1_rvalid    <= 1'b0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner        <= pick;
            lat_we       <= pick_we;
            mem_addr     <= pick_addr;
            mem_data_in  <= pick_wdata;
            mem_write_en <= pick_we;
            mem_read_en  <= !pick_we;
            ext_gnt      <= (pick == OWN_EXT);
            c0_gnt       <= (pick == OWN_C0);
            c1_gnt       <= (pick == OWN_C1);
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (owner == OWN_C0) rr_last <= 1'b0;
          if (owner == OWN_C1) rr_last <= 1'b1;
          if (lat_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (cnt == '0) begin
            case (owner)
              OWN_EXT: begin
                ext_rdata  <= mem_data_out;
                ext_rvalid <= 1'b1;
              end
              OWN_C0: begin
                c0_rdata  <= mem_data_out;
                c0_rvalid <= 1'b1;
              end
              default: begin
                c1_rdata  <= mem_data_out;
                c1_rvalid <= 1'b1;
              end
            endcase
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: one RD_LAT=1 instance (a) and one RD_LAT=3
// instance (b) sharing requester inputs, each with its own RAM model.
module tb_dram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ext_req = 0, c0_req = 0, c1_req = 0;
  logic        ext_we = 0, c0_we = 0, c1_we = 0;
  logic [8:0]  ext_addr = '0, c0_addr = '0, c1_addr = '0;
  logic [15:0] ext_wdata = '0, c0_wdata = '0, c1_wdata = '0;

  logic        ext_gnt_a, c0_gnt_a, c1_gnt_a, ext_rv_a, c0_rv_a, c1_rv_a;
  logic [15:0] ext_rd_a, c0_rd_a, c1_rd_a;
  logic        we_a, re_a, busy_a;
  logic [8:0]  addr_a;
  logic [15:0] din_a, dout_a;

  logic        ext_gnt_b, c0_gnt_b, c1_gnt_b, ext_rv_b, c0_rv_b, c1_rv_b;
  logic [15:0] ext_rd_b, c0_rd_b, c1_rd_b;
  logic        we_b, re_b, busy_b;
  logic [8:0]  addr_b;
  logic [15:0] din_b, dout_b, d1_b, d2_b;

  logic [15:0] ram_a [512];
  logic [15:0] ram_b [512];

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  dram_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(1)) u_a (
    .clock(clock), .reset_n(reset_n),
    .ext_req(ext_req), .c0_req(c0_req), .c1_req(c1_req),
    .ext_we(ext_we), .c0_we(c0_we), .c1_we(c1_we),
    .ext_addr(ext_addr), .c0_addr(c0_addr), .c1_addr(c1_addr),
    .ext_wdata(ext_wdata), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .ext_gnt(ext_gnt_a), .c0_gnt(c0_gnt_a), .c1_gnt(c1_gnt_a),
    .ext_rvalid(ext_rv_a), .c0_rvalid(c0_rv_a), .c1_rvalid(c1_rv_a),
    .ext_rdata(ext_rd_a), .c0_rdata(c0_rd_a), .c1_rdata(c1_rd_a),
    .mem_write_en(we_a), .mem_read_en(re_a), .mem_addr(addr_a),
    .mem_data_in(din_a), .mem_data_out(dout_a), .busy(busy_a)
  );

  dram_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(3)) u_b (
    .clock(clock), .reset_n(reset_n),
    .ext_req(ext_req), .c0_req(c0_req), .c1_req(c1_req),
    .ext_we(ext_we), .c0_we(c0_we), .c1_we(c1_we),
    .ext_addr(ext_addr), .c0_addr(c0_addr), .c1_addr(c1_addr),
    .ext_wdata(ext_wdata), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .ext_gnt(ext_gnt_b), .c0_gnt(c0_gnt_b), .c1_gnt(c1_gnt_b),
    .ext_rvalid(ext_rv_b), .c0_rvalid(c0_rv_b), .c1_rvalid(c1_rv_b),
    .ext_rdata(ext_rd_b), .c0_rdata(c0_rd_b), .c1_rdata(c1_rd_b),
    .mem_write_en(we_b), .mem_read_en(re_b), .mem_addr(addr_b),
    .mem_data_in(din_b), .mem_data_out(dout_b), .busy(busy_b)
  );

  // RAM contents reload to 0xA000|addr whenever reset is low at a clock edge.
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 512; i++) ram_a[i] <= 16'hA000 | 16'(i);
    end else begin
      if (we_a) ram_a[addr_a] <= din_a;
      if (re_a) dout_a <= ram_a[addr_a];
    end
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 512; i++) ram_b[i] <= 16'hA000 | 16'(i);
    end else begin
      if (we_b) ram_b[addr_b] <= din_b;
      if (re_b) d1_b <= ram_b[addr_b];
      d2_b   <= d1_b;
      dout_b <= d2_b;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic c0_turn;

    tick();
    tick();
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_c0_gnt", c0_gnt_a, 1'b0);
    chk1("rst_we", we_a, 1'b0);
    chk1("rst_re", re_a, 1'b0);
    chkd("rst_addr", 16'(addr_a), 16'h0000);
    chkd("rst_c0_rdata", c0_rd_a, 16'h0000);
    reset_n = 1'b1;
    tick();

    // c0 write 0x005 = 0xBEEF, then read it back
    c0_req = 1; c0_we = 1; c0_addr = 9'h005; c0_wdata = 16'hBEEF;
    tick();
    chk1("wr_c0_gnt", c0_gnt_a, 1'b1);
    chk1("wr_we", we_a, 1'b1);
    chk1("wr_re", re_a, 1'b0);
    chkd("wr_addr", 16'(addr_a), 16'h0005);
    chkd("wr_din", din_a, 16'hBEEF);
    chk1("wr_busy", busy_a, 1'b1);
    c0_req = 0;
    tick();
    chk1("wr_gnt_drop", c0_gnt_a, 1'b0);
    chk1("wr_we_drop", we_a, 1'b0);
    chk1("wr_busy_drop", busy_a, 1'b0);
    c0_req = 1; c0_we = 0;
    tick();
    chk1("rd_c0_gnt", c0_gnt_a, 1'b1);
    chk1("rd_re", re_a, 1'b1);
    chk1("rd_we", we_a, 1'b0);
    c0_req = 0;
    tick();
    chk1("rd_wait_rv", c0_rv_a, 1'b0);
    chk1("rd_wait_re", re_a, 1'b0);
    chk1("rd_wait_busy", busy_a, 1'b1);
    chkd("rd_wait_addr", 16'(addr_a), 16'h0005);
    tick();
    chk1("rd_c0_rvalid", c0_rv_a, 1'b1);
    chkd("rd_c0_rdata", c0_rd_a, 16'hBEEF);
    chk1("rd_c1_rvalid", c1_rv_a, 1'b0);
    chk1("rd_busy_end", busy_a, 1'b0);
    tick();
    chk1("rd_rvalid_pulse", c0_rv_a, 1'b0);
    chkd("rd_rdata_hold", c0_rd_a, 16'hBEEF);

    // continuous c0/c1 reads alternate, c0 first after reset
    pulse_reset();
    c0_req = 1; c0_we = 0; c0_addr = 9'h010;
    c1_req = 1; c1_we = 0; c1_addr = 9'h011;
    c0_turn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk1("rr_c0_gnt", c0_gnt_a, c0_turn);
      chk1("rr_c1_gnt", c1_gnt_a, !c0_turn);
      tick();
      tick();
      chk1("rr_c0_rv", c0_rv_a, c0_turn);
      chk1("rr_c1_rv", c1_rv_a, !c0_turn);
      if (c0_turn) chkd("rr_c0_rdata", c0_rd_a, 16'hA010);
      else         chkd("rr_c1_rdata", c1_rd_a, 16'hA011);
      c0_turn = !c0_turn;
    end
    c0_req = 0; c1_req = 0;
    tick();

    // ext beats both cores; rr order (c0 next) is untouched by the ext grant
    pulse_reset();
    ext_req = 1; ext_we = 1; ext_addr = 9'h1FF; ext_wdata = 16'h1234;
    c0_req = 1; c1_req = 1;
    tick();
    chk1("ext_gnt", ext_gnt_a, 1'b1);
    chk1("ext_c0_gnt", c0_gnt_a, 1'b0);
    chk1("ext_c1_gnt", c1_gnt_a, 1'b0);
    chkd("ext_addr", 16'(addr_a), 16'h01FF);
    chkd("ext_din", din_a, 16'h1234);
    ext_req = 0;
    tick();
    tick();
    chk1("ext_then_c0", c0_gnt_a, 1'b1);
    chk1("ext_then_c1_no", c1_gnt_a, 1'b0);
    c0_req = 0;
    tick();
    tick();
    chkd("ext_c0_rdata", c0_rd_a, 16'hA010);
    tick();
    chk1("ext_then_c1", c1_gnt_a, 1'b1);
    c1_req = 0;
    tick();
    tick();
    chk1("ext_c1_rv", c1_rv_a, 1'b1);
    chkd("ext_c1_rdata", c1_rd_a, 16'hA011);
    ext_req = 1; ext_we = 0;
    tick();
    chk1("ext_rd_gnt", ext_gnt_a, 1'b1);
    ext_req = 0;
    tick();
    tick();
    chk1("ext_rd_rv", ext_rv_a, 1'b1);
    chkd("ext_rd_data", ext_rd_a, 16'h1234);

    // reset during RDWAIT of a c1 read
    tick();
    c1_req = 1; c1_we = 0; c1_addr = 9'h011;
    tick();
    chk1("rr_c1_gnt", c1_gnt_a, 1'b1);
    c1_req = 0;
    tick();
    chk1("rw_busy_pre", busy_a, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("rw_busy_async", busy_a, 1'b0);
    chk1("rw_re_async", re_a, 1'b0);
    chkd("rw_c1_rdata_clr", c1_rd_a, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    chk1("rw_no_c1_rv", c1_rv_a, 1'b0);
    tick();
    chk1("rw_no_c1_rv2", c1_rv_a, 1'b0);
    c0_req = 1; c0_we = 0; c0_addr = 9'h020;
    tick();
    chk1("rw_c0_gnt", c0_gnt_a, 1'b1);
    c0_req = 0;
    tick();
    tick();
    chk1("rw_c0_rv", c0_rv_a, 1'b1);
    chkd("rw_c0_rdata", c0_rd_a, 16'hA020);

    // reset during ISSUE drops the write strobe at once
    tick();
    c0_req = 1; c0_we = 1; c0_addr = 9'h021; c0_wdata = 16'h5555;
    tick();
    chk1("ri_we_pre", we_a, 1'b1);
    c0_req = 0;
    reset_n = 1'b0;
    #1;
    chk1("ri_we_async", we_a, 1'b0);
    chk1("ri_gnt_async", c0_gnt_a, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // back-to-back c0 writes with req held high
    c0_req = 1; c0_we = 1; c0_addr = 9'h030; c0_wdata = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("b2b_gnt", c0_gnt_a, 1'b1);
      chkd("b2b_addr", 16'(addr_a), 16'h0030 + 16'(i));
      chkd("b2b_din", din_a, 16'h0001 + 16'(i));
      c0_addr = 9'h031 + 9'(i);
      c0_wdata = 16'h0002 + 16'(i);
      tick();
      chk1("b2b_gap", c0_gnt_a, 1'b0);
    end
    c0_req = 0;
    tick();

    // RD_LAT=3 instance: c1 read
    pulse_reset();
    c1_req = 1; c1_we = 0; c1_addr = 9'h044;
    tick();
    chk1("l3_gnt", c1_gnt_b, 1'b1);
    chk1("l3_busy0", busy_b, 1'b1);
    c1_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("l3_busy", busy_b, 1'b1);
      chk1("l3_no_rv", c1_rv_b, 1'b0);
    end
    tick();
    chk1("l3_rv", c1_rv_b, 1'b1);
    chkd("l3_rdata", c1_rd_b, 16'hA044);
    chk1("l3_busy_end", busy_b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
